mem_bus_arbiter: RTL

Two-master arbiter for the shared memory-mapped bus in front of the memory map decoder (data RAM, instruction ROM, GPIO, UART). It lets the multicycle core (master 0) and a second master, such as a UART boot loader or debug DMA (master 1), share the single bus port. Arbitration is round-robin, with an optional bounded lock for atomic bursts. Bus commands are registered, and read data is returned with a per-master valid strobe that tracks the synchronous memory's one-cycle read latency.

---
 rtl/mem_bus_arbiter.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Round-robin arbiter that lets two masters share one memory-mapped bus
// port. Master 0 is normally the core and master 1 a boot loader or DMA.
// A master may hold a bounded lock on the bus for atomic bursts. Bus
// commands leave this block registered. Read data comes back with a
// per-master valid strobe that allows for the memory's one-cycle read
// latency.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req/we/lock/addr/wdata{0,1}   master command fields, held until granted
//   gnt0, gnt1            combinational grant (req & gnt at an edge = accepted)
//   rvalid0, rvalid1      registered read-data-valid per master
//   rdata0, rdata1        read data (wired to bus_rdata), qualify with rvalidN
//   bus_addr, bus_wdata   registered command to the decoder
//   bus_re, bus_we        registered one-cycle strobes, mutually exclusive
//   bus_rdata             read data from the bus, one cycle after bus_re
//   owner                 registered master that issued the current strobe
module mem_bus_arbiter #(
    parameter int ADDR_LENGTH = 32,
    parameter int DATA_LENGTH = 32,
    parameter int LOCK_MAX    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0,
    input  logic                   we0,
    input  logic                   lock0,
    input  logic [ADDR_LENGTH-1:0] addr0,
    input  logic [DATA_LENGTH-1:0] wdata0,
    input  logic                   req1,
    input  logic                   we1,
    input  logic                   lock1,
    input  logic [ADDR_LENGTH-1:0] addr1,
    input  logic [DATA_LENGTH-1:0] wdata1,
    output logic                   gnt0,
    output logic                   gnt1,
    output logic                   rvalid0,
    output logic                   rvalid1,
    output logic [DATA_LENGTH-1:0] rdata0,
    output logic [DATA_LENGTH-1:0] rdata1,
    output logic [ADDR_LENGTH-1:0] bus_addr,
    output logic [DATA_LENGTH-1:0] bus_wdata,
    output logic                   bus_re,
    output logic                   bus_we,
    input  logic [DATA_LENGTH-1:0] bus_rdata,
    output logic                   owner
);

    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The beat that brings the count to LOCK_MAX is the last locked beat,
    // so the lock is kept only while the current count is below LOCK_MAX-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);
    // With LOCK_MAX of 1 a single beat already uses the whole budget,
    // so a lock request can never extend ownership.
    localparam bit CAN_LOCK = (LOCK_MAX > 1);

    typedef enum logic [1:0] {
        MODE_OPEN  = 2'd0,
        MODE_LOCK0 = 2'd1,
        MODE_LOCK1 = 2'd2
    } mode_t;

    mode_t                  mode_r;
    mode_t                  mode_nxt_s;
    logic                   last_r;
    logic [CNT_W-1:0]       lock_cnt_r;
    logic [CNT_W-1:0]       lock_cnt_nxt_s;
    logic                   gnt0_s;
    logic                   gnt1_s;
    logic                   acc0_s;
    logic                   acc1_s;
    logic                   acc_s;
    logic                   sel_we_s;
    logic                   sel_lock_s;
    logic [ADDR_LENGTH-1:0] sel_addr_s;
    logic [DATA_LENGTH-1:0] sel_wdata_s;
    logic [ADDR_LENGTH-1:0] bus_addr_r;
    logic [DATA_LENGTH-1:0] bus_wdata_r;
    logic                   bus_re_r;
    logic                   bus_we_r;
    logic                   owner_r;
    logic                   rvalid0_r;
    logic                   rvalid1_r;

    // Grant decode: round-robin on a tie when open, only the owner when locked.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        case (mode_r)
            MODE_OPEN: begin
                if (req0 && req1) begin
                    // The master that did not win last time gets the grant.
                    gnt0_s = last_r;
                    gnt1_s = ~last_r;
                end else begin
                    gnt0_s = req0;
                    gnt1_s = req1;
                end
            end
            MODE_LOCK0: gnt0_s = req0;
            MODE_LOCK1: gnt1_s = req1;
            default: begin
                gnt0_s = 1'b0;
                gnt1_s = 1'b0;
            end
        endcase
    end

    assign acc0_s = req0 & gnt0_s;
    assign acc1_s = req1 & gnt1_s;
    assign acc_s  = acc0_s | acc1_s;

    // Command mux: pick the fields of the master being accepted.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (acc1_s) begin
            sel_we_s    = we1;
            sel_lock_s  = lock1;
            sel_addr_s  = addr1;
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_lock_s  = lock0;
            sel_addr_s  = addr0;
            sel_wdata_s = wdata0;
        end
    end

    // Lock state: enter, extend, release on budget, or abandon on dropped req.
    always_comb begin
        mode_nxt_s     = mode_r;
        lock_cnt_nxt_s = lock_cnt_r;
        if (acc_s) begin
            if (mode_r == MODE_OPEN) begin
                if (sel_lock_s && CAN_LOCK) begin
                    mode_nxt_s     = acc1_s ? MODE_LOCK1 : MODE_LOCK0;
                    lock_cnt_nxt_s = CNT_ONE;
                end else begin
                    mode_nxt_s     = MODE_OPEN;
                    lock_cnt_nxt_s = CNT_ZERO;
                end
            end else begin
                // Only the lock owner can be accepted while locked.
                if (sel_lock_s && (lock_cnt_r < CNT_LAST)) begin
                    mode_nxt_s     = mode_r;
                    lock_cnt_nxt_s = lock_cnt_r + CNT_ONE;
                end else begin
                    mode_nxt_s     = MODE_OPEN;
                    lock_cnt_nxt_s = CNT_ZERO;
                end
            end
        end else begin
            case (mode_r)
                MODE_OPEN: begin
                    mode_nxt_s     = MODE_OPEN;
                    lock_cnt_nxt_s = CNT_ZERO;
                end
                MODE_LOCK0: begin
                    if (!req0) begin
                        mode_nxt_s     = MODE_OPEN;
                        lock_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        mode_nxt_s     = mode_r;
                        lock_cnt_nxt_s = lock_cnt_r;
                    end
                end
                MODE_LOCK1: begin
                    if (!req1) begin
                        mode_nxt_s     = MODE_OPEN;
                        lock_cnt_nxt_s = CNT_ZERO;
                    end else begin
                        mode_nxt_s     = mode_r;
                        lock_cnt_nxt_s = lock_cnt_r;
                    end
                end
                default: begin
                    // An illegal encoding recovers to the open state.
                    mode_nxt_s     = MODE_OPEN;
                    lock_cnt_nxt_s = CNT_ZERO;
                end
            endcase
        end
    end

    // Arbiter state, registered bus command and read-return pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r      <= MODE_OPEN;
            last_r      <= 1'b1;
            lock_cnt_r  <= CNT_ZERO;
            bus_addr_r  <= '0;
            bus_wdata_r <= '0;
            bus_re_r    <= 1'b0;
            bus_we_r    <= 1'b0;
            owner_r     <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
        end else begin
            mode_r     <= mode_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            bus_re_r   <= acc_s & ~sel_we_s;
            bus_we_r   <= acc_s & sel_we_s;
            // The read issued last cycle returns now to whoever issued it.
            rvalid0_r  <= bus_re_r & ~owner_r;
            rvalid1_r  <= bus_re_r & owner_r;
            if (acc_s) begin
                bus_addr_r  <= sel_addr_s;
                bus_wdata_r <= sel_wdata_s;
                owner_r     <= acc1_s;
                // Also covers a forced release: the other master wins a tie next.
                last_r      <= acc1_s;
            end
        end
    end

    assign gnt0      = gnt0_s;
    assign gnt1      = gnt1_s;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign rdata0    = bus_rdata;
    assign rdata1    = bus_rdata;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_re    = bus_re_r;
    assign bus_we    = bus_we_r;
    assign owner     = owner_r;

endmodule
